// File: rtl/hpb_wr_master.sv
// Host-programming write channel initiator: buffers host writes in a small FIFO and
// replays each one as a held request to the RAM controller, with timeout recovery.
module hpb_wr_master #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16,
    localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_wr_valid,
    output logic                  host_wr_ready,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    input  logic [BE_WIDTH-1:0]   host_wr_be,
    output logic                  hpb_wr_req,
    output logic [ADDR_WIDTH-1:0] hpb_wr_addr,
    output logic [DATA_WIDTH-1:0] hpb_wr_data,
    output logic [BE_WIDTH-1:0]   hpb_wr_byte_en,
    input  logic                  rcb_wr_done,
    input  logic                  err_clr,
    output logic                  timeout_err,
    output logic                  protocol_err,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [BE_WIDTH-1:0]   fifo_be   [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        fifo_count;
    logic                  fifo_empty, fifo_full, push;

    logic             load, done_ok, expire, stray_done;
    logic [TMO_W-1:0] tmo_cnt;

    assign fifo_empty    = (fifo_count == '0);
    assign fifo_full     = (fifo_count == FULL_CNT);
    assign host_wr_ready = !fifo_full;
    assign push          = host_wr_valid && !fifo_full;
    assign busy          = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_wr_addr;
            fifo_data[wr_ptr] <= host_wr_data;
            fifo_be[wr_ptr]   <= host_wr_be;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Done takes priority over an expiring timeout in the same cycle.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        done_ok    = 1'b0;
        expire     = 1'b0;
        stray_done = rcb_wr_done && (state != REQ);
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                if (rcb_wr_done) begin
                    done_ok    = 1'b1;
                    next_state = RELEASE;
                end else if (tmo_cnt == TMO_LAST) begin
                    expire     = 1'b1;
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    next_state = REQ;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request payload only changes on a load so it stays stable while req is held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hpb_wr_req     <= 1'b0;
            hpb_wr_addr    <= '0;
            hpb_wr_data    <= '0;
            hpb_wr_byte_en <= '0;
            tmo_cnt        <= '0;
            wr_cnt         <= '0;
            drop_cnt       <= '0;
            timeout_err    <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            hpb_wr_req <= (next_state == REQ);
            if (load) begin
                hpb_wr_addr    <= fifo_addr[rd_ptr];
                hpb_wr_data    <= fifo_data[rd_ptr];
                hpb_wr_byte_en <= fifo_be[rd_ptr];
                tmo_cnt        <= '0;
            end else if (state == REQ && next_state == REQ) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (done_ok) wr_cnt   <= wr_cnt + 1'b1;
            if (expire)  drop_cnt <= drop_cnt + 1'b1;
            if (expire)       timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
            if (stray_done)   protocol_err <= 1'b1;
            else if (err_clr) protocol_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hpb_wr_master.sv
// Self-checking bench for hpb_wr_master: per-cycle transaction-level model plus
// a cycle table for the single-write case and directed corner-case sequences.
module tb_hpb_wr_master;

    localparam int AW    = 14;
    localparam int DW    = 64;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          host_wr_valid = 1'b0;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic [BW-1:0] host_wr_be = '0;
    logic          hpb_wr_req;
    logic [AW-1:0] hpb_wr_addr;
    logic [DW-1:0] hpb_wr_data;
    logic [BW-1:0] hpb_wr_byte_en;
    logic          rcb_wr_done = 1'b0;
    logic          err_clr = 1'b0;
    logic          timeout_err, protocol_err;
    logic [CW-1:0] wr_cnt, drop_cnt;
    logic          busy;

    always #5 clk = ~clk;

    hpb_wr_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_wr_be(host_wr_be),
        .hpb_wr_req(hpb_wr_req), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
        .hpb_wr_byte_en(hpb_wr_byte_en), .rcb_wr_done(rcb_wr_done), .err_clr(err_clr),
        .timeout_err(timeout_err), .protocol_err(protocol_err),
        .wr_cnt(wr_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } cmd_t;

    typedef struct {
        logic          valid;
        logic          done;
        logic          clr;
        logic          exp_req;
        logic          exp_ready;
        logic          exp_busy;
        logic [CW-1:0] exp_wr;
        logic          exp_perr;
    } vec_t;

    // Reference model: queue of accepted-but-unissued commands plus the request in flight.
    cmd_t q[$];
    cmd_t m_out;
    bit   m_req, m_rel, m_terr, m_perr;
    int   m_hi, m_lat, m_wr, m_drop;
    int   resp_lat;
    bit   auto_resp;
    bit   pushed_last;
    bit   ready_low_seen;
    int   checks, errors;
    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        bit   push_now, done_now, clr_now, rst_now, was_req, fell, tmo_now;
        cmd_t c;
        push_now = host_wr_valid && (q.size() < DEPTH);
        done_now = rcb_wr_done;
        clr_now  = err_clr;
        rst_now  = !reset_n;
        c.addr   = host_wr_addr;
        c.data   = host_wr_data;
        c.be     = host_wr_be;
        @(posedge clk);
        #1;
        pushed_last = push_now && !rst_now;
        if (rst_now) begin
            q.delete();
            m_req = 0; m_rel = 0; m_hi = 0; m_wr = 0; m_drop = 0;
            m_terr = 0; m_perr = 0;
            m_out = '{default: '0};
        end else begin
            was_req = m_req;
            fell    = 0;
            tmo_now = 0;
            if (was_req) begin
                if (done_now) begin
                    fell = 1; m_wr++;
                end else if (m_hi == TO) begin
                    fell = 1; m_drop++; tmo_now = 1;
                end else begin
                    m_hi++;
                end
                if (fell) m_req = 0;
            end else if (q.size() > 0) begin
                m_out = q.pop_front();
                m_req = 1; m_hi = 1; m_lat = resp_lat;
            end
            m_rel = fell;
            if (tmo_now) m_terr = 1;
            else if (clr_now) m_terr = 0;
            if (done_now && !was_req) m_perr = 1;
            else if (clr_now) m_perr = 0;
            if (push_now) q.push_back(c);
        end
        checkOutput("req", hpb_wr_req, m_req);
        checkOutput("addr", hpb_wr_addr, m_out.addr);
        checkOutput("data", hpb_wr_data, m_out.data);
        checkOutput("byte_en", hpb_wr_byte_en, m_out.be);
        checkOutput("ready", host_wr_ready, q.size() < DEPTH);
        checkOutput("busy", busy, (q.size() > 0) || m_req || m_rel);
        checkOutput("wr_cnt", wr_cnt, 16'(m_wr));
        checkOutput("drop_cnt", drop_cnt, 16'(m_drop));
        checkOutput("timeout_err", timeout_err, m_terr);
        checkOutput("protocol_err", protocol_err, m_perr);
        if (host_wr_ready === 1'b0) ready_low_seen = 1;
        if (auto_resp) rcb_wr_done = m_req && (m_hi == m_lat);
    endtask

    task automatic applyStimulus(input vec_t v);
        host_wr_valid = v.valid;
        host_wr_addr  = 14'h0123;
        host_wr_data  = 64'hDEADBEEF_CAFEF00D;
        host_wr_be    = 8'hFF;
        rcb_wr_done   = v.done;
        err_clr       = v.clr;
        tick();
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        host_wr_be    = b;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pushed_last) break;
        end
        if (!pushed_last) begin
            checks++; errors++;
            $display("[TB] FAIL push_accept: got no acceptance, expected acceptance within 200 cycles");
        end
        host_wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit idle;
        idle = 0;
        for (int i = 0; i < bound; i++) begin
            if (q.size() == 0 && !m_req && !m_rel) begin
                idle = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("[TB] FAIL wait_idle: got still busy, expected idle within %0d cycles", bound);
        end
    endtask

    task automatic pulse_clear();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    function automatic vec_t mk(bit v, bit d, bit c, bit r, bit rdy, bit b, int wr, bit pe);
        vec_t x;
        x.valid = v; x.done = d; x.clr = c;
        x.exp_req = r; x.exp_ready = rdy; x.exp_busy = b;
        x.exp_wr = 16'(wr); x.exp_perr = pe;
        return x;
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        return (r == 0) ? 0 : r + 1;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Single write (controller answers in the second req cycle) then a stray done and clear.
        vecs[0] = mk(1, 0, 0, 0, 1, 1, 0, 0);
        vecs[1] = mk(0, 0, 0, 1, 1, 1, 0, 0);
        vecs[2] = mk(0, 0, 0, 1, 1, 1, 0, 0);
        vecs[3] = mk(0, 1, 0, 0, 1, 1, 1, 0);
        vecs[4] = mk(0, 0, 0, 0, 1, 0, 1, 0);
        vecs[5] = mk(0, 1, 0, 0, 1, 0, 1, 1);
        vecs[6] = mk(0, 0, 1, 0, 1, 0, 1, 0);
        vecs[7] = mk(0, 0, 0, 0, 1, 0, 1, 0);

        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        checkOutput("reset req", hpb_wr_req, 1'b0);
        checkOutput("reset ready", host_wr_ready, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset wr_cnt", wr_cnt, 16'd0);

        auto_resp = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d req", i), hpb_wr_req, vecs[i].exp_req);
            checkOutput($sformatf("vec%0d ready", i), host_wr_ready, vecs[i].exp_ready);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            checkOutput($sformatf("vec%0d wr_cnt", i), wr_cnt, vecs[i].exp_wr);
            checkOutput($sformatf("vec%0d protocol_err", i), protocol_err, vecs[i].exp_perr);
        end
        rcb_wr_done = 1'b0;
        err_clr     = 1'b0;
        checkOutput("single addr held", hpb_wr_addr, 14'h0123);
        checkOutput("single data held", hpb_wr_data, 64'hDEADBEEF_CAFEF00D);
        checkOutput("single be held", hpb_wr_byte_en, 8'hFF);

        // Burst of six into a four-deep FIFO with a responsive controller.
        auto_resp      = 1;
        resp_lat       = 2;
        ready_low_seen = 0;
        for (int i = 0; i < 6; i++)
            push(14'(16'h0200 + i), {32'h1111_0000 + 32'(i), 32'hA5A5_0000 + 32'(i)}, 8'(8'h0F << (i % 5)));
        checkOutput("burst ready dropped", ready_low_seen, 1'b1);
        wait_idle(100);
        checkOutput("burst wr_cnt", wr_cnt, 16'd7);

        // Controller stalls five extra cycles.
        resp_lat = 7;
        push(14'h0300, 64'h0123_4567_89AB_CDEF, 8'h3C);
        wait_idle(100);
        checkOutput("stall wr_cnt", wr_cnt, 16'd8);
        checkOutput("stall timeout_err", timeout_err, 1'b0);

        // First request never answered, second queued behind it is answered.
        resp_lat = 0;
        push(14'h0400, 64'hFFFF_0000_FFFF_0000, 8'hF0);
        push(14'h0401, 64'h0000_FFFF_0000_FFFF, 8'h0F);
        resp_lat = 2;
        wait_idle(100);
        checkOutput("timeout drop_cnt", drop_cnt, 16'd1);
        checkOutput("timeout wr_cnt", wr_cnt, 16'd9);
        checkOutput("timeout flag set", timeout_err, 1'b1);
        pulse_clear();
        checkOutput("timeout flag cleared", timeout_err, 1'b0);

        // Done arrives in the last cycle before the timeout would fire.
        resp_lat = TO;
        push(14'h0500, 64'h5555_AAAA_5555_AAAA, 8'h81);
        wait_idle(100);
        checkOutput("edge wr_cnt", wr_cnt, 16'd10);
        checkOutput("edge drop_cnt", drop_cnt, 16'd1);
        checkOutput("edge timeout_err", timeout_err, 1'b0);

        // Randomized traffic with mixed controller latencies, some beyond the timeout.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) begin
                resp_lat = pick_lat();
                tick();
            end
            resp_lat = pick_lat();
            push(AW'($urandom), {$urandom, $urandom}, BW'($urandom));
        end
        wait_idle(600);
        checkOutput("random total", wr_cnt + drop_cnt, 16'd51);

        // Reset while a request is held and two more are queued.
        resp_lat = 0;
        push(14'h0600, 64'h1, 8'h01);
        push(14'h0601, 64'h2, 8'h02);
        push(14'h0602, 64'h3, 8'h04);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("midreset req", hpb_wr_req, 1'b0);
        checkOutput("midreset ready", host_wr_ready, 1'b1);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset wr_cnt", wr_cnt, 16'd0);
        checkOutput("midreset drop_cnt", drop_cnt, 16'd0);
        repeat (6) tick();
        checkOutput("postreset req", hpb_wr_req, 1'b0);
        checkOutput("postreset busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
